// File: rtl/reg_file_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
package reg_file_mp_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ctrl_state_t;
endpackage

// File: rtl/reg_file_mp_rf_read_port.sv
// One read port: stored data, or same-cycle write data when RF_BYPASS_EN is defined.
module rf_read_port
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic [WIDTH-1:0]  stored,
    input  logic              wr_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [WIDTH-1:0]  wd_a,
    input  logic              wr_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [WIDTH-1:0]  wd_b,
    output logic [WIDTH-1:0]  rd
);
`ifdef RF_BYPASS_EN
    // wr_a/wr_b arrive already qualified: enabled, nonzero, not dropped
    always_comb begin
        rd = stored;
        if (wr_a && (wa_a == ra)) rd = wd_a;
        if (wr_b && (wa_b == ra)) rd = wd_b;
    end
`else
    logic unused_byp;
    assign unused_byp = ^{wr_a, wa_a, wd_a, wr_b, wa_b, wd_b};
    assign rd = stored;
`endif
endmodule

// File: rtl/reg_file_mp.sv
// Two-write, two-read register file with sequential clear controller.
// Optional same-cycle write-to-read bypass: define RF_BYPASS_EN.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [WIDTH-1:0]  wd_a,
    input  logic [WIDTH-1:0]  wd_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    ctrl_state_t       state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic              clr_en, done_n, drop_n;
    logic              wr_a, wr_b;

    assign busy = (state == CLEAR);
    assign wr_a = we_a && (wa_a != '0) && !busy;
    assign wr_b = we_b && (wa_b != '0) && !busy;
    assign drop_n = busy && ((we_a && (wa_a != '0)) ||
                             (we_b && (wa_b != '0)));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        clr_en  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_n = CLEAR;
                    idx_n   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (idx == LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            clr_done <= done_n;
            wr_drop  <= drop_n;
        end
    end

    // Port B is applied last so it wins a same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (clr_en) mem[idx] <= '0;
            if (wr_a) mem[wa_a] <= wd_a;
            if (wr_b) mem[wa_b] <= wd_b;
        end
    end

    rf_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rp1 (
        .ra     (ra1),
        .stored (mem[ra1]),
        .wr_a   (wr_a),
        .wa_a   (wa_a),
        .wd_a   (wd_a),
        .wr_b   (wr_b),
        .wa_b   (wa_b),
        .wd_b   (wd_b),
        .rd     (rd1)
    );

    rf_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rp2 (
        .ra     (ra2),
        .stored (mem[ra2]),
        .wr_a   (wr_a),
        .wa_a   (wa_a),
        .wd_a   (wd_a),
        .wr_b   (wr_b),
        .wa_b   (wa_b),
        .wd_b   (wd_b),
        .rd     (rd2)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard testbench for reg_file_mp (works with or without RF_BYPASS_EN).
module tb_reg_file_mp;
    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ra1, ra2, wa_a, wa_b;
    logic [W-1:0]  rd1, rd2, wd_a, wd_b;
    logic          we_a, we_b, clr_req;
    logic          busy, clr_done, wr_drop;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] model [DEPTH];
    logic [W-1:0] exp_q [$];

    reg_file_mp #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .we_a     (we_a),
        .we_b     (we_b),
        .wa_a     (wa_a),
        .wa_b     (wa_b),
        .wd_a     (wd_a),
        .wd_b     (wd_b),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        we_a = 1'b0;
        we_b = 1'b0;
        clr_req = 1'b0;
        wa_a = '0;
        wa_b = '0;
        wd_a = '0;
        wd_b = '0;
    endtask

    task automatic test_reset;
        logic [W-1:0] e;
        idle_in();
        ra1 = 5'd5;
        ra2 = 5'd0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #2;
        checks++;
        if (busy !== 1'b0 || clr_done !== 1'b0 || wr_drop !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b%b exp=000", busy, clr_done, wr_drop);
        end
        exp_q.push_back(model[5]);
        e = exp_q.pop_front();
        checks++;
        if (rd1 !== e) begin
            failures++;
            $display("FAIL reset_rd1 got=%h exp=%h", rd1, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        logic [W-1:0] e;
        step();
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
        we_b = 1'b1; wa_b = 5'd12; wd_b = 32'hCAFE0012;
        step();
        model[5] = 32'hDEADBEEF;
        model[12] = 32'hCAFE0012;
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'h12345678;
        we_b = 1'b0;
        ra1 = 5'd5; ra2 = 5'd0;
        exp_q.push_back(model[5]);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rd1 !== e) begin
            failures++;
            $display("FAIL wr_rd1 got=%h exp=%h", rd1, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (rd2 !== e) begin
            failures++;
            $display("FAIL wr_rd2_zero got=%h exp=%h", rd2, e);
        end
        step();
        idle_in();
        ra1 = 5'd0; ra2 = 5'd12;
        exp_q.push_back(32'h0);
        exp_q.push_back(model[12]);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rd1 !== e) begin
            failures++;
            $display("FAIL addr0_ignored got=%h exp=%h", rd1, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (rd2 !== e) begin
            failures++;
            $display("FAIL portb_wr got=%h exp=%h", rd2, e);
        end
        checks++;
        if (wr_drop !== 1'b0) begin
            failures++;
            $display("FAIL addr0_drop got=%b exp=0", wr_drop);
        end
    endtask

    task automatic test_same_addr;
        logic [W-1:0] e;
        step();
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h11;
        we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h22;
        step();
        idle_in();
        model[7] = 32'h22;
        ra1 = 5'd7;
        exp_q.push_back(model[7]);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rd1 !== e) begin
            failures++;
            $display("FAIL same_addr got=%h exp=%h", rd1, e);
        end
        checks++;
        if (wr_drop !== 1'b0) begin
            failures++;
            $display("FAIL same_addr_drop got=%b exp=0", wr_drop);
        end
    endtask

    task automatic test_bypass;
        logic [W-1:0] e;
        step();
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h33;
        we_b = 1'b1; wa_b = 5'd10; wd_b = 32'h44;
        step();
        model[9] = 32'h33;
        model[10] = 32'h44;
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h55;
        we_b = 1'b0;
        ra1 = 5'd9;
`ifdef RF_BYPASS_EN
        exp_q.push_back(32'h55);
`else
        exp_q.push_back(model[9]);
`endif
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rd1 !== e) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h exp=%h", rd1, e);
        end
        step();
        model[9] = 32'h55;
        we_a = 1'b1; wa_a = 5'd10; wd_a = 32'h66;
        we_b = 1'b1; wa_b = 5'd10; wd_b = 32'h77;
        ra2 = 5'd10;
        exp_q.push_back(model[9]);
`ifdef RF_BYPASS_EN
        exp_q.push_back(32'h77);
`else
        exp_q.push_back(model[10]);
`endif
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rd1 !== e) begin
            failures++;
            $display("FAIL bypass_next_cycle got=%h exp=%h", rd1, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (rd2 !== e) begin
            failures++;
            $display("FAIL bypass_b_prio got=%h exp=%h", rd2, e);
        end
        step();
        idle_in();
        model[10] = 32'h77;
    endtask

    task automatic test_clear;
        int bcnt, dcnt, dcyc;
        logic [W-1:0] e, old20, old31;
        bcnt = 0; dcnt = 0; dcyc = 0;
        for (int i = 1; i < DEPTH; i++) begin
            step();
            we_a = 1'b1; wa_a = AW'(i);
            wd_a = 32'h1000_0000 + 32'(i) * 3 + 1;
            model[i] = wd_a;
        end
        step();
        idle_in();
        clr_req = 1'b1;
        ra1 = 5'd20; ra2 = 5'd31;
        old20 = model[20];
        old31 = model[31];
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_req_cycle_busy got=%b exp=0", busy);
        end
        for (int c = 1; c <= 40; c++) begin
            step();
            clr_req = (c >= 2 && c <= 25);
            exp_q.push_back((c <= 20) ? old20 : 32'h0);
            exp_q.push_back((c <= 31) ? old31 : 32'h0);
            @(negedge clk);
            if (busy) bcnt++;
            if (clr_done) begin
                dcnt++;
                dcyc = c;
            end
            e = exp_q.pop_front();
            checks++;
            if (rd1 !== e) begin
                failures++;
                $display("FAIL clr_read20 c=%0d got=%h exp=%h", c, rd1, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (rd2 !== e) begin
                failures++;
                $display("FAIL clr_read31 c=%0d got=%h exp=%h", c, rd2, e);
            end
        end
        clr_req = 1'b0;
        checks++;
        if (bcnt != 31) begin
            failures++;
            $display("FAIL clr_busy_cycles got=%0d exp=31", bcnt);
        end
        checks++;
        if (dcnt != 1 || dcyc != 32) begin
            failures++;
            $display("FAIL clr_done_pulse got=%0d@%0d exp=1@32", dcnt, dcyc);
        end
        for (int i = 1; i < DEPTH; i++) model[i] = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ra1 = AW'(a);
            ra2 = AW'(DEPTH - 1 - a);
            exp_q.push_back(model[a]);
            exp_q.push_back(model[DEPTH - 1 - a]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rd1 !== e) begin
                failures++;
                $display("FAIL post_clr_rd1 a=%0d got=%h exp=%h", a, rd1, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (rd2 !== e) begin
                failures++;
                $display("FAIL post_clr_rd2 a=%0d got=%h exp=%h", a, rd2, e);
            end
        end
    endtask

    task automatic test_write_busy;
        logic seen;
        logic [W-1:0] e;
        seen = 1'b0;
        step();
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'hABC;
        step();
        idle_in();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h777;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_drop !== 1'b0) begin
            failures++;
            $display("FAIL busy_wr_cycle got=%b%b exp=10", busy, wr_drop);
        end
        step();
        we_a = 1'b0;
        we_b = 1'b1; wa_b = 5'd0; wd_b = 32'h999;
        @(negedge clk);
        checks++;
        if (wr_drop !== 1'b1) begin
            failures++;
            $display("FAIL busy_wr_drop got=%b exp=1", wr_drop);
        end
        step();
        we_b = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_drop !== 1'b0) begin
            failures++;
            $display("FAIL busy_addr0_drop got=%b exp=0", wr_drop);
        end
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            @(negedge clk);
            if (clr_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL busy_wr_timeout got=no_done exp=done");
        end
        model[3] = '0;
        ra1 = 5'd3;
        exp_q.push_back(model[3]);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rd1 !== e) begin
            failures++;
            $display("FAIL busy_wr_lost got=%h exp=%h", rd1, e);
        end
    endtask

    task automatic test_reset_mid_clear;
        int bcnt, dcnt;
        logic [W-1:0] e;
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            we_a = 1'b1;
            wa_a = (i == 0) ? 5'd4 : (i == 1) ? 5'd8 : 5'd31;
            wd_a = 32'hF00 + 32'(i);
        end
        step();
        idle_in();
        clr_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            clr_req = 1'b0;
            we_a = (c == 9);
            wa_a = 5'd4;
            @(negedge clk);
        end
        we_a = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_drop !== 1'b1) begin
            failures++;
            $display("FAIL mid_clr_pre got=%b%b exp=11", busy, wr_drop);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || clr_done !== 1'b0 || wr_drop !== 1'b0) begin
            failures++;
            $display("FAIL mid_clr_rst got=%b%b%b exp=000", busy, clr_done, wr_drop);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ra1 = AW'(a);
            exp_q.push_back(model[a]);
            #0.1;
            e = exp_q.pop_front();
            checks++;
            if (rd1 !== e) begin
                failures++;
                $display("FAIL mid_clr_rd a=%0d got=%h exp=%h", a, rd1, e);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (clr_done) dcnt++;
            step();
        end
        checks++;
        if (bcnt != 31 || dcnt != 1) begin
            failures++;
            $display("FAIL rst_reclear got=%0d/%0d exp=31/1", bcnt, dcnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_addr();
        test_bypass();
        test_clear();
        test_write_busy();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
